lsu_mem_master: RTL

Load/store unit that sits between the single-cycle datapath's memory stage and the word-addressed data memory `dmem`, and acts as the initiator on the `we`/`addr`/`writedata`/`readdata` interface. It accepts byte, halfword and word loads and stores from the CPU through a valid/ready request port. Sub-word stores are performed as a read-modify-write, because the memory only writes whole words. Each request returns exactly one response pulse, carrying aligned and sign/zero-extended load data and an error flag.

---
 rtl/lsu_mem_master_if.sv | 40 ++++
 rtl/lsu_mem_master.sv | 137 +++++++++++++
 2 files changed

// File: rtl/lsu_mem_master_if.sv
// Bus bundles for the load/store unit: the CPU request/response port
// and the word-wide data-memory port.

interface lsu_req_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

interface lsu_mem_if;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );
    modport slave (
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/lsu_mem_master.sv
// Load/store unit: byte/halfword/word accesses to a word-only memory,
// sub-word stores done as read-modify-write, one response per request.

module lsu_mem_master #(
    parameter int MEM_WORDS = 64
) (
    input  logic      clk,
    input  logic      reset,
    lsu_req_if.slave  req,
    lsu_mem_if.master mem
);

    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

    localparam logic [1:0]  SZ_BYTE    = 2'b00;
    localparam logic [1:0]  SZ_HALF    = 2'b01;
    localparam logic [1:0]  SZ_WORD    = 2'b10;
    localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

    state_t      state, state_nx;
    logic        l_we, l_signed;
    logic [1:0]  l_size;
    logic [31:0] l_addr, l_wdata;
    logic [31:0] merge_q, rdata_q;
    logic        err_q;

    logic        accept, req_err;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_val, merge_val;

    assign accept = (state == IDLE) && req.req_valid;

    always_comb begin
        case (req.req_size)
            SZ_BYTE: req_err = 1'b0;
            SZ_HALF: req_err = req.req_addr[0];
            SZ_WORD: req_err = |req.req_addr[1:0];
            default: req_err = 1'b1;
        endcase
        if (req.req_addr[31:2] >= WORD_LIMIT)
            req_err = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req.req_valid) state_nx = req_err ? RESP : ACCESS;
            ACCESS:  state_nx = (l_we && l_size != SZ_WORD) ? WRITE : RESP;
            WRITE:   state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Lane extraction for loads and lane replacement for sub-word stores.
    always_comb begin
        byte_v    = mem.mem_rdata[{l_addr[1:0], 3'b000} +: 8];
        half_v    = mem.mem_rdata[{l_addr[1], 4'b0000} +: 16];
        merge_val = mem.mem_rdata;
        if (l_size == SZ_BYTE)
            merge_val[{l_addr[1:0], 3'b000} +: 8] = l_wdata[7:0];
        else
            merge_val[{l_addr[1], 4'b0000} +: 16] = l_wdata[15:0];
        case (l_size)
            SZ_BYTE: load_val = {{24{l_signed & byte_v[7]}}, byte_v};
            SZ_HALF: load_val = {{16{l_signed & half_v[15]}}, half_v};
            default: load_val = mem.mem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            l_we     <= 1'b0;
            l_signed <= 1'b0;
            l_size   <= '0;
            l_addr   <= '0;
            l_wdata  <= '0;
            merge_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                l_we     <= req.req_we;
                l_signed <= req.req_signed;
                l_size   <= req.req_size;
                l_addr   <= req.req_addr;
                l_wdata  <= req.req_wdata;
                // Leaving IDLE always enters ACCESS or RESP: clear the result.
                rdata_q  <= '0;
                err_q    <= req_err;
            end
            if (state == ACCESS) begin
                if (!l_we) rdata_q <= load_val;
                merge_q <= merge_val;
            end
        end
    end

    // NOTE: every output gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        req.req_ready  = 1'b0;
        req.resp_valid = 1'b0;
        mem.mem_we     = 1'b0;
        mem.mem_addr   = '0;
        mem.mem_wdata  = '0;
        case (state)
            IDLE: req.req_ready = 1'b1;
            ACCESS: begin
                mem.mem_addr = {l_addr[31:2], 2'b00};
                if (l_we && l_size == SZ_WORD) begin
                    mem.mem_we    = 1'b1;
                    mem.mem_wdata = l_wdata;
                end
            end
            WRITE: begin
                mem.mem_addr  = {l_addr[31:2], 2'b00};
                mem.mem_we    = 1'b1;
                mem.mem_wdata = merge_q;
            end
            RESP:    req.resp_valid = 1'b1;
            default: ;
        endcase
    end

    assign req.resp_rdata = rdata_q;
    assign req.resp_err   = err_q;

endmodule
